// File: rtl/pipe_share_ctrl_pkg.sv
// pipe_share_ctrl_pkg: slot states and default latency shared by the pipeline-sharing controller
//   SLOT_IDLE / SLOT_INFLIGHT / SLOT_HOLD : per-requester slot states
//   LATENCY_DEF : edges from issue until pipe_out holds the result
package pipe_share_ctrl_pkg;
    typedef enum logic [1:0] {
        SLOT_IDLE     = 2'd0,
        SLOT_INFLIGHT = 2'd1,
        SLOT_HOLD     = 2'd2
    } slot_t;
    localparam int LATENCY_DEF = 2;
endpackage

// File: rtl/pipe_share_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, combinational, one-hot or zero grant
//   elig[1:0] : requesters allowed to issue this cycle
//   last_gnt  : id of the most recent grant; the other one wins a tie
//   gnt[1:0]  : grant vector
module rr_arb2 (
    input  logic [1:0] elig,
    input  logic       last_gnt,
    output logic [1:0] gnt
);
    always_comb
        gnt = &elig ? (last_gnt ? 2'b01 : 2'b10) : elig;
endmodule

// File: rtl/pipe_share_ctrl.sv
// pipe_share_ctrl: shares one registered NOT/AND pipeline between two requesters
//   clk, reset                 : clock, asynchronous active-low reset
//   reqN, aN, bN, gntN         : requester N operation request, operands, issue accepted
//   rspN_valid, rspN_data      : requester N held result, (~a)&b of its issued operation
//   rspN_ack                   : consumes the requester N result
//   pipe_in1, pipe_in2         : operands driven into the pipeline on the issue cycle
//   pipe_out                   : pipeline result, LATENCY edges after issue
//   busy                       : an issue, an in-flight operation or a held result exists
module pipe_share_ctrl
    import pipe_share_ctrl_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic a0,
    input  logic b0,
    output logic gnt0,
    output logic rsp0_valid,
    output logic rsp0_data,
    input  logic rsp0_ack,
    input  logic req1,
    input  logic a1,
    input  logic b1,
    output logic gnt1,
    output logic rsp1_valid,
    output logic rsp1_data,
    input  logic rsp1_ack,
    output logic pipe_in1,
    output logic pipe_in2,
    input  logic pipe_out,
    output logic busy
);
    slot_t              slot [2];
    logic [LATENCY-1:0] trk_v;
    logic [LATENCY-1:0] trk_id;
    logic [1:0]         req;
    logic [1:0]         ack;
    logic [1:0]         elig;
    logic [1:0]         gnt;
    logic [1:0]         rsp_data;
    logic               last_gnt;

    assign req  = {req1, req0};
    assign ack  = {rsp1_ack, rsp0_ack};
    // Gating with reset keeps gnt low while the reset is asserted.
    assign elig = {2{reset}} & req & {slot[1] == SLOT_IDLE, slot[0] == SLOT_IDLE};

    rr_arb2 u_arb (
        .elig     (elig),
        .last_gnt (last_gnt),
        .gnt      (gnt)
    );

    assign {gnt1, gnt0}             = gnt;
    assign pipe_in1                 = gnt[0] ? a0 : gnt[1] & a1;
    assign pipe_in2                 = gnt[0] ? b0 : gnt[1] & b1;
    assign {rsp1_valid, rsp0_valid} = {slot[1] == SLOT_HOLD, slot[0] == SLOT_HOLD};
    assign {rsp1_data, rsp0_data}   = rsp_data;
    assign busy = (|gnt) | (|trk_v) | (slot[0] != SLOT_IDLE) | (slot[1] != SLOT_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot     <= '{SLOT_IDLE, SLOT_IDLE};
            trk_v    <= '0;
            trk_id   <= '0;
            rsp_data <= '0;
            last_gnt <= 1'b1;
        end else begin
            if (|gnt)
                last_gnt <= gnt[1];
            trk_v[0]  <= |gnt;
            trk_id[0] <= gnt[1];
            for (int i = 1; i < LATENCY; i++) begin
                trk_v[i]  <= trk_v[i-1];
                trk_id[i] <= trk_id[i-1];
            end
            // The tracker head marks the edge at which pipe_out holds that requester's result.
            for (int i = 0; i < 2; i++) begin
                if (gnt[i])
                    slot[i] <= SLOT_INFLIGHT;
                else if (slot[i] == SLOT_INFLIGHT && trk_v[LATENCY-1] && trk_id[LATENCY-1] == 1'(i)) begin
                    slot[i]     <= SLOT_HOLD;
                    rsp_data[i] <= pipe_out;
                end else if (slot[i] == SLOT_HOLD && ack[i])
                    slot[i] <= SLOT_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_pipe_share_ctrl.sv
// tb_pipe_share_ctrl: directed and randomized checks of pipe_share_ctrl against a transaction-level model
module tb_pipe_share_ctrl;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic req0 = 0, a0 = 0, b0 = 0, rsp0_ack = 0;
    logic req1 = 0, a1 = 0, b1 = 0, rsp1_ack = 0;
    logic gnt0, gnt1, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data;
    logic pipe_in1, pipe_in2, pipe_out, busy;
    logic p1, p2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_share_ctrl #(.LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .a0         (a0),
        .b0         (b0),
        .gnt0       (gnt0),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_ack   (rsp0_ack),
        .req1       (req1),
        .a1         (a1),
        .b1         (b1),
        .gnt1       (gnt1),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_ack   (rsp1_ack),
        .pipe_in1   (pipe_in1),
        .pipe_in2   (pipe_in2),
        .pipe_out   (pipe_out),
        .busy       (busy)
    );

    // The shared pipeline: two input flops, then (~in1)&in2 into the output flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1       <= 1'b0;
            p2       <= 1'b0;
            pipe_out <= 1'b0;
        end else begin
            p1       <= pipe_in1;
            p2       <= pipe_in2;
            pipe_out <= ~p1 & p2;
        end
    end

    // Reference model: one outstanding operation per requester, result due LAT+1 cycles after issue.
    int  cyc;
    bit  outst [2];
    int  issue_cyc [2];
    bit  exp_data [2];
    bit  m_last;
    bit  o_gnt [2];
    bit  o_v [2];
    bit  o_d [2];
    bit  o_busy;

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        outst  = '{0, 0};
        m_last = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        {req0, req1, rsp0_ack, rsp1_ack} = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        cyc = 0;
    endtask

    // One cycle: apply inputs after the edge, check at the falling edge, then advance the model.
    task automatic cycle(input bit rs, input bit r0, input bit x0, input bit y0, input bit k0,
                         input bit r1, input bit x1, input bit y1, input bit k1);
        bit el0, el1, eg0, eg1, ev0, ev1;
        req0 = r0; a0 = x0; b0 = y0; rsp0_ack = k0;
        req1 = r1; a1 = x1; b1 = y1; rsp1_ack = k1;
        if (rs) begin
            reset = 1'b0;
            model_reset();
        end
        el0 = r0 && !outst[0] && !rs;
        el1 = r1 && !outst[1] && !rs;
        eg0 = el0 && !(el1 && !m_last);
        eg1 = el1 && !(el0 && m_last);
        ev0 = outst[0] && cyc >= issue_cyc[0] + LAT + 1;
        ev1 = outst[1] && cyc >= issue_cyc[1] + LAT + 1;
        #4;
        chk("gnt0", gnt0, eg0);
        chk("gnt1", gnt1, eg1);
        chk("pipe_in1", pipe_in1, eg0 ? x0 : eg1 && x1);
        chk("pipe_in2", pipe_in2, eg0 ? y0 : eg1 && y1);
        chk("rsp0_valid", rsp0_valid, ev0);
        chk("rsp1_valid", rsp1_valid, ev1);
        if (ev0) chk("rsp0_data", rsp0_data, exp_data[0]);
        if (ev1) chk("rsp1_data", rsp1_data, exp_data[1]);
        chk("busy", busy, eg0 | eg1 | outst[0] | outst[1]);
        o_gnt  = '{gnt0, gnt1};
        o_v    = '{rsp0_valid, rsp1_valid};
        o_d    = '{rsp0_data, rsp1_data};
        o_busy = busy;
        @(posedge clk);
        #1 reset = 1'b1;
        if (k0 && ev0) outst[0] = 0;
        if (k1 && ev1) outst[1] = 0;
        if (eg0) begin outst[0] = 1; issue_cyc[0] = cyc; exp_data[0] = ~x0 & y0; m_last = 0; end
        if (eg1) begin outst[1] = 1; issue_cyc[1] = cyc; exp_data[1] = ~x1 & y1; m_last = 1; end
        cyc++;
    endtask

    initial begin
        int  n;
        bit  prev;
        cyc = 0;
        model_reset();
        #3;
        chk("reset_gnt0", gnt0, 1'b0);
        chk("reset_rsp0_valid", rsp0_valid, 1'b0);
        chk("reset_rsp1_valid", rsp1_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);

        // Single issue and its result at cycle 3.
        do_reset();
        cycle(0, 1, 0, 1, 0, 0, 0, 0, 0);
        chk("t1_gnt0_c0", o_gnt[0], 1'b1);
        chk("t1_busy_c0", o_busy, 1'b1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_busy_c2", o_busy, 1'b1);
        cycle(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("t1_valid_c3", o_v[0], 1'b1);
        chk("t1_data_c3", o_d[0], 1'b1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_busy_c4", o_busy, 1'b0);

        // Tie at cycle 0: requester 0 first, requester 1 next.
        do_reset();
        cycle(0, 1, 1, 1, 0, 1, 0, 1, 0);
        chk("t2_gnt0_c0", o_gnt[0], 1'b1);
        cycle(0, 1, 1, 1, 0, 1, 0, 1, 0);
        chk("t2_gnt1_c1", o_gnt[1], 1'b1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("t2_valid0_c3", o_v[0], 1'b1);
        chk("t2_data0_c3", o_d[0], 1'b0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t2_valid1_c4", o_v[1], 1'b1);
        chk("t2_data1_c4", o_d[1], 1'b1);

        // No regrant while the result is held; regrant the cycle after ack.
        do_reset();
        for (int c = 0; c < 5; c++) cycle(0, 1, 0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 1, 1, 0, 0, 0, 0);
        chk("t3_gnt0_c5", o_gnt[0], 1'b0);
        chk("t3_valid_c5", o_v[0], 1'b1);
        cycle(0, 1, 0, 1, 0, 0, 0, 0, 0);
        chk("t3_gnt0_c6", o_gnt[0], 1'b1);

        // Both held with immediate acks: strict alternation, no starvation.
        do_reset();
        n = 0;
        prev = 1'b1;
        for (int c = 0; c < 44; c++) begin
            cycle(0, 1, $urandom_range(1), $urandom_range(1), 1, 1, $urandom_range(1), $urandom_range(1), 1);
            if (o_gnt[0] | o_gnt[1]) begin
                chk("t4_alternate", o_gnt[1], !prev);
                prev = o_gnt[1];
                n++;
            end
        end
        chk("t4_20_issues", n >= 20, 1'b1);

        // Reset while an operation is in flight.
        do_reset();
        cycle(0, 1, 0, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_busy_after", o_busy, 1'b0);
        for (int c = 0; c < 4; c++) begin
            cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("t5_no_valid", o_v[0], 1'b0);
        end
        cycle(0, 1, 0, 1, 0, 0, 0, 0, 0);
        chk("t5_regrant", o_gnt[0], 1'b1);
        for (int c = 0; c < 4; c++) cycle(0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Stray ack, and ack0 coincident with the capture for requester 1.
        do_reset();
        cycle(0, 1, 1, 0, 0, 1, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("t6_valid0", o_v[0], 1'b1);
        chk("t6_data0", o_d[0], 1'b0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t6_valid0_gone", o_v[0], 1'b0);
        chk("t6_valid1", o_v[1], 1'b1);
        chk("t6_data1", o_d[1], 1'b1);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 400; c++)
            cycle($urandom_range(59) == 0,
                  $urandom_range(3) != 0, $urandom_range(1), $urandom_range(1), $urandom_range(1),
                  $urandom_range(3) != 0, $urandom_range(1), $urandom_range(1), $urandom_range(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
